frame_packetizer: RTL
=====================

# frame_packetizer

Multi-channel successor to the single-source scope-to-packet-sender path. It accepts N_CH independent frame streams (32-bit valid/ready plus a frame-ready strobe and frame size) and arbitrates them round-robin. Each frame is split into packets of at most MAX_PKT_WORDS payload words, and each packet gets a one-word header. The output is a single stream with an explicit packet-start strobe and byte length, and it feeds the UDP packet sender directly.

## Interface
- N_CH, 4, number of source channels (1..16)
- DW, 32, data word width (header layout requires 32)
- SIZE_W, 16, width of frame size in 32-bit words
- MAX_PKT_WORDS, 256, max payload words per packet (1..16382)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_frame_ready  in  N_CH  one-cycle strobe per channel: frame complete, size valid
- i_frame_size  in  N_CH*SIZE_W  per-channel frame size in words, sampled on strobe
- i_in_data  in  N_CH*DW  per-channel payload data
- i_in_vld  in  N_CH  per-channel payload valid
- o_in_rdy  out  N_CH  per-channel payload ready
- o_out_data  out  DW  header/payload word
- o_out_vld  out  1  output valid
- i_out_rdy  in  1  output ready
- o_out_sop  out  1  marks header word
- o_out_eop  out  1  marks last word of packet
- o_pkt_start  out  1  one-cycle strobe, packet about to start
- o_pkt_len  out  16  packet length in bytes incl. header, valid with o_pkt_start, held until next strobe
- o_busy  out  1  high outside IDLE
- o_ovf_cnt  out  16  count of strobes lost on already-pending channels, saturating

## Operation
- Per channel: pending bit and latched size. An i_frame_ready strobe on a channel that is not pending sets the pending bit and latches the size. A strobe on an already-pending channel is ignored and increments o_ovf_cnt (saturates at 0xFFFF).
- State machine: IDLE, START, HDR, DATA.
- IDLE: if any channel is pending, grant the first pending channel searching from last_grant+1 (mod N_CH). On grant: clear that channel's pending bit, load remaining = latched size, set frag = 0, go to START. If the size is 0, only the pending bit is cleared; no packet is sent, seq is unchanged, and the block stays in IDLE.
- START: frag_words = min(remaining, MAX_PKT_WORDS). Pulse o_pkt_start. o_pkt_len = (frag_words+1)*4. Go to HDR.
- HDR: o_out_vld=1, o_out_sop=1, o_out_data = header. Header fields:
  - [31:24] = 8'hA5
  - [23:20] = channel
  - [19] = last-fragment flag
  - [18:16] = 0
  - [15:8] = seq[ch]
  - [7:0] = frag
  - Go to DATA on i_out_rdy.
- DATA: combinational pass-through of the granted channel:
  - o_out_vld = i_in_vld[g]
  - o_in_rdy[g] = i_out_rdy
  - o_out_data = i_in_data[g]
  - All other o_in_rdy are 0.
  - Each handshake decrements the fragment count and remaining.
  - o_out_eop is asserted on the last word of the fragment.
- After the eop handshake: if remaining > 0, frag += 1 (8-bit wrap) and go to START. Otherwise seq[ch] += 1 (8-bit wrap) and go to IDLE.
- A strobe on the granted channel during transmission sets its pending bit normally, because pending was cleared at grant.

## Timing
- Reset values:
  - all outputs 0; o_pkt_len 0; o_ovf_cnt 0
  - all pending bits 0, seq 0
  - last_grant = N_CH-1, so channel 0 wins first
  - state IDLE
- Strobe to o_pkt_start: 2 cycles minimum (strobe registers pending; IDLE grant; START pulse).
- The header is presented the cycle after o_pkt_start and is held until i_out_rdy.
- Between fragments: 1 cycle in START with o_out_vld=0.
- Throughput in DATA: 1 word per cycle when source valid and sink ready are both high.
- Rule: o_out_vld must not depend on i_out_rdy. Payload data never passes without a handshake on both sides.
- Reset mid-packet: the next cycle is IDLE with all pending bits cleared. The partially sent packet is abandoned without an eop.

## Structure
- Shared package holds: the header magic constant 8'hA5, header field bit positions, the state enum, and the byte-length computation function.
- One sub-module, frame_rr_arbiter (N_CH request vector, last_grant in, grant index and valid out, combinational), instanced once.
- The channel mux and counters stay in the top.

## Test plan
- Single frame on ch0 with size 10, MAX=256, sink always ready:
  - o_pkt_start with o_pkt_len=44
  - header 0xA5080000, then 10 words, eop on the 10th
  - seq[0] becomes 1
- Ch2 size 600, MAX=256:
  - three packets with lengths 1028, 1028, 356
  - frag 0, 1, 2; last flag set only on the third
  - 1 idle cycle between packets
- Simultaneous strobes on ch1 and ch3 with last_grant=1: ch3 is served first, then ch1.
  - Re-strobe ch3 while it is being sent: ch3 is served again after ch1.
- Random sink backpressure (50%) and source gaps on a size-37 frame: word order preserved, no duplicates, header held stable while i_out_rdy is low.
- Edge cases:
  - Double strobe on pending ch0 gives o_ovf_cnt=1 and keeps the first size.
  - Size 0 gives no o_pkt_start.
  - rst asserted in DATA: state IDLE and pending 0 on the next cycle.

Source files
------------

// File: rtl/frame_packetizer_pkg.sv
// frame_packetizer_pkg: shared header layout, FSM states and length helper
package frame_packetizer_pkg;
  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_CH_LSB = 20;
  localparam int HDR_LAST_BIT = 19;
  localparam int HDR_SEQ_LSB = 8;
  localparam int HDR_FRAG_LSB = 0;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_HDR = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;
  function automatic logic [15:0] pkt_bytes(input logic [15:0] words);
    return 16'((32'(words) + 32'd1) * 32'd4);
  endfunction
endpackage

// File: rtl/frame_rr_arbiter.sv
// frame_rr_arbiter: combinational round-robin pick starting after the last grant
module frame_rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CW = 2
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CW-1:0]   last_i,
  output logic [CW-1:0]   gnt_o,
  output logic            vld_o
);
  // scan farthest to nearest so the nearest pending channel after last_i wins
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    for (int i = N_CH; i >= 1; i--) begin
      if (req_i[(int'(last_i) + i) % N_CH]) begin
        gnt_o = CW'((int'(last_i) + i) % N_CH);
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/frame_packetizer.sv
// frame_packetizer: round-robin multi-channel frame to header+payload packet stream
module frame_packetizer
  import frame_packetizer_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW = 32,
  parameter int SIZE_W = 16,
  parameter int MAX_PKT_WORDS = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        i_frame_ready,
  input  logic [N_CH*SIZE_W-1:0] i_frame_size,
  input  logic [N_CH*DW-1:0]     i_in_data,
  input  logic [N_CH-1:0]        i_in_vld,
  output logic [N_CH-1:0]        o_in_rdy,
  output logic [DW-1:0]          o_out_data,
  output logic                   o_out_vld,
  input  logic                   i_out_rdy,
  output logic                   o_out_sop,
  output logic                   o_out_eop,
  output logic                   o_pkt_start,
  output logic [15:0]            o_pkt_len,
  output logic                   o_busy,
  output logic [15:0]            o_ovf_cnt
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [SIZE_W-1:0] MAXW = SIZE_W'(MAX_PKT_WORDS);
  logic [1:0] state_q, state_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [SIZE_W-1:0] size_q [N_CH];
  logic [7:0] seq_q [N_CH];
  logic [CW-1:0] last_q, ch_q, gnt;
  logic arb_vld;
  logic [SIZE_W-1:0] rem_q, cnt_q, fw;
  logic [7:0] frag_q;
  logic lastf_q;
  logic [15:0] len_q, ovf_q, ovf_d;
  logic [4:0] n_lost;
  logic [16:0] ovf_sum;
  logic hs, lastw;
  logic [31:0] hdr;

  frame_rr_arbiter #(.N_CH(N_CH), .CW(CW)) u_arb (
    .req_i(pend_q), .last_i(last_q), .gnt_o(gnt), .vld_o(arb_vld)
  );

  assign fw = (rem_q > MAXW) ? MAXW : rem_q;
  assign hs = (state_q == S_DATA) && i_in_vld[ch_q] && i_out_rdy;
  assign lastw = (cnt_q == SIZE_W'(1));

  // next state, pending bookkeeping and saturating overflow count
  always_comb begin
    unique case (state_q)
      S_IDLE:  state_d = (arb_vld && size_q[gnt] != '0) ? S_START : S_IDLE;
      S_START: state_d = S_HDR;
      S_HDR:   state_d = i_out_rdy ? S_DATA : S_HDR;
      default: state_d = !(hs && lastw) ? S_DATA : (rem_q != SIZE_W'(1) ? S_START : S_IDLE);
    endcase
    pend_d = pend_q | i_frame_ready;
    if (state_q == S_IDLE && arb_vld) pend_d[gnt] = 1'b0;
    n_lost = '0;
    for (int c = 0; c < N_CH; c++) n_lost = n_lost + 5'(pend_q[c] & i_frame_ready[c]);
    ovf_sum = {1'b0, ovf_q} + 17'(n_lost);
    ovf_d = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
  end

  // header word assembled from the packed field positions
  always_comb begin
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
    hdr[HDR_CH_LSB +: 4] = 4'(ch_q);
    hdr[HDR_LAST_BIT] = lastf_q;
    hdr[HDR_SEQ_LSB +: 8] = seq_q[ch_q];
    hdr[HDR_FRAG_LSB +: 8] = frag_q;
  end

  // output stream: header in HDR, direct source pass-through in DATA
  always_comb begin
    o_busy = state_q != S_IDLE;
    o_pkt_start = state_q == S_START;
    o_pkt_len = o_pkt_start ? pkt_bytes(16'(fw)) : len_q;
    o_out_sop = state_q == S_HDR;
    o_out_vld = o_out_sop || (state_q == S_DATA && i_in_vld[ch_q]);
    o_out_eop = state_q == S_DATA && i_in_vld[ch_q] && lastw;
    o_out_data = (state_q == S_DATA) ? i_in_data[ch_q*DW +: DW] : (o_out_sop ? hdr : '0);
    o_in_rdy = '0;
    o_in_rdy[ch_q] = state_q == S_DATA && i_out_rdy;
    o_ovf_cnt = ovf_q;
  end

  // state, per-channel capture, grant loading and fragment counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q <= '0;
      last_q <= CW'(N_CH - 1);
      ch_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      frag_q <= '0;
      lastf_q <= 1'b0;
      len_q <= '0;
      ovf_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        size_q[c] <= '0;
        seq_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
      for (int c = 0; c < N_CH; c++)
        if (i_frame_ready[c] && !pend_q[c]) size_q[c] <= i_frame_size[c*SIZE_W +: SIZE_W];
      if (state_q == S_IDLE && arb_vld) begin
        last_q <= gnt;
        ch_q <= gnt;
        rem_q <= size_q[gnt];
        frag_q <= '0;
      end
      if (state_q == S_START) begin
        cnt_q <= fw;
        lastf_q <= rem_q <= MAXW;
        len_q <= pkt_bytes(16'(fw));
      end
      if (hs) begin
        cnt_q <= cnt_q - SIZE_W'(1);
        rem_q <= rem_q - SIZE_W'(1);
        if (lastw && rem_q != SIZE_W'(1)) frag_q <= frag_q + 8'd1;
        if (lastw && rem_q == SIZE_W'(1)) seq_q[ch_q] <= seq_q[ch_q] + 8'd1;
      end
    end
  end
endmodule
